// File: rtl/hash_pkg.sv
// hash_pkg: shared state encoding, widths and mix/finalise helpers for the multi-way key hasher
package hash_pkg;
  typedef enum logic [1:0] {IDLE, MIX, FIN, DONE} state_t;
  localparam int HASH_W = 32;
  localparam int unsigned DEF_ROT = 5;
  localparam logic [HASH_W-1:0] DEF_MULT = 32'h9E37_79B1;
  function automatic logic [HASH_W-1:0] hash_mix(input logic [HASH_W-1:0] h, input logic [HASH_W-1:0] chunk,
                                                  input int unsigned rot, input logic [HASH_W-1:0] mult);
    logic [HASH_W-1:0] x, r;
    logic [2*HASH_W-1:0] p;
    x = h ^ chunk;
    r = (x << (rot % HASH_W)) | (x >> ((HASH_W - rot % HASH_W) % HASH_W));
    p = {{HASH_W{1'b0}}, r} * {{HASH_W{1'b0}}, mult};
    return p[HASH_W-1:0];
  endfunction
  function automatic logic [HASH_W-1:0] hash_fin(input logic [HASH_W-1:0] h);
    return h ^ (h >> 16);
  endfunction
endpackage

// File: rtl/hash_lane.sv
// hash_lane: one way's running hash register and its held result, driven by strobes from the shared FSM
module hash_lane import hash_pkg::*; #(
  parameter int unsigned ROT = DEF_ROT,
  parameter logic [HASH_W-1:0] MULT = DEF_MULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_mix,
  input  logic              i_fin,
  input  logic [HASH_W-1:0] i_seed,
  input  logic [HASH_W-1:0] i_chunk,
  output logic [HASH_W-1:0] o_val
);
  logic [HASH_W-1:0] r_h, r_val;
  // running hash: seed on accept, one chunk per mix cycle, finalise result into the held output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h   <= '0;
      r_val <= '0;
    end else begin
      r_h <= i_load ? i_seed : i_mix ? hash_mix(r_h, i_chunk, ROT, MULT) : r_h;
      if (i_fin) r_val <= hash_fin(r_h);
    end
  end
  assign o_val = r_val;
endmodule

// File: rtl/hash_multi.sv
// hash_multi: iterative NUM_WAYS-way seeded key hasher; HASH_MULTI_SEED_PROG_EN adds runtime seed registers
module hash_multi import hash_pkg::*; #(
  parameter int KEY_W = 64,
  parameter int NUM_WAYS = 2,
  parameter logic [NUM_WAYS*HASH_W-1:0] SEEDS = {32'h0000_0000, 32'h5bd1_e995},
  parameter int unsigned ROT = DEF_ROT,
  parameter logic [HASH_W-1:0] MULT = DEF_MULT
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef HASH_MULTI_SEED_PROG_EN
  input  logic                         seed_we_i,
  input  logic [((NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1)-1:0] seed_idx_i,
  input  logic [HASH_W-1:0]            seed_i,
`endif
  input  logic                         start_i,
  input  logic [KEY_W-1:0]             key_i,
  output logic                         busy_o,
  output logic                         hash_ready_o,
  output logic [NUM_WAYS*HASH_W-1:0]   hash_val_o
);
  localparam int N = KEY_W / HASH_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  generate
    if ((KEY_W % HASH_W) != 0 || KEY_W < HASH_W || NUM_WAYS < 1 || NUM_WAYS > 8) begin : g_bad_cfg
      $fatal(1, "hash_multi: KEY_W must be a positive multiple of 32 and NUM_WAYS in 1..8");
    end
  endgenerate
  state_t r_state, w_next;
  logic [KEY_W-1:0] r_key;
  logic [CW-1:0] r_cnt;
  logic r_ready, w_accept, w_mix, w_fin, w_last;
  logic [HASH_W-1:0] w_chunk;
  logic [NUM_WAYS*HASH_W-1:0] w_seed;
`ifdef HASH_MULTI_SEED_PROG_EN
  logic [NUM_WAYS*HASH_W-1:0] r_seed;
  // runtime seeds; out-of-range indices are dropped, and the lanes only read them on accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_seed <= SEEDS;
    else if (seed_we_i && int'(seed_idx_i) < NUM_WAYS) r_seed[seed_idx_i*HASH_W +: HASH_W] <= seed_i;
  end
  assign w_seed = r_seed;
`else
  assign w_seed = SEEDS;
`endif
  assign w_last = r_cnt == CW'(N - 1);
  assign w_chunk = r_key[r_cnt*HASH_W +: HASH_W];
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state: accept from IDLE/DONE, walk chunks in MIX, one finalise cycle
  always_comb begin
    w_next = w_accept ? MIX : (r_state == MIX && w_last) ? FIN : (r_state == FIN) ? DONE : r_state;
  end
  // decoded strobes for the lanes and the busy flag
  always_comb begin
    w_accept = start_i && (r_state == IDLE || r_state == DONE);
    w_mix = r_state == MIX;
    w_fin = r_state == FIN;
    busy_o = w_mix || w_fin;
  end
  // key latch, chunk counter and result-valid flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key   <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      if (w_accept) r_key <= key_i;
      r_cnt <= w_accept ? '0 : w_mix ? r_cnt + 1'b1 : r_cnt;
      r_ready <= w_accept ? 1'b0 : w_fin ? 1'b1 : r_ready;
    end
  end
  assign hash_ready_o = r_ready;
  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_lane
    hash_lane #(.ROT(ROT), .MULT(MULT)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_accept),
      .i_mix   (w_mix),
      .i_fin   (w_fin),
      .i_seed  (w_seed[w*HASH_W +: HASH_W]),
      .i_chunk (w_chunk),
      .o_val   (hash_val_o[w*HASH_W +: HASH_W])
    );
  end
endmodule

// File: tb/tb_hash_multi.sv
// tb_hash_multi: directed checks of the default 2-way hasher and a 32-bit single-way instance
module tb_hash_multi;
  logic clk = 1'b0, rst = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [63:0] key0 = '0;
  logic [31:0] key1 = '0;
  logic busy0, ready0, busy1, ready1;
  logic [63:0] val0;
  logic [31:0] val1;
  logic [63:0] prev;
  int n_chk = 0, n_fail = 0;
`ifdef HASH_MULTI_SEED_PROG_EN
  logic we0 = 1'b0, we1 = 1'b0;
  logic idx0 = 1'b0, idx1 = 1'b0;
  logic [31:0] sd0 = '0, sd1 = '0;
`endif
  always #5 clk = ~clk;
  hash_multi u_dut0 (
    .clk(clk), .rst(rst),
`ifdef HASH_MULTI_SEED_PROG_EN
    .seed_we_i(we0), .seed_idx_i(idx0), .seed_i(sd0),
`endif
    .start_i(start0), .key_i(key0), .busy_o(busy0), .hash_ready_o(ready0), .hash_val_o(val0));
  hash_multi #(.KEY_W(32), .NUM_WAYS(1), .SEEDS(32'h0)) u_dut1 (
    .clk(clk), .rst(rst),
`ifdef HASH_MULTI_SEED_PROG_EN
    .seed_we_i(we1), .seed_idx_i(idx1), .seed_i(sd1),
`endif
    .start_i(start1), .key_i(key1), .busy_o(busy1), .hash_ready_o(ready1), .hash_val_o(val1));
  function automatic logic [31:0] ref_hash(input logic [63:0] key, input int n, input logic [31:0] seed);
    logic [31:0] h, x;
    logic [63:0] d, p;
    h = seed;
    for (int k = 0; k < n; k++) begin
      x = h ^ key[k*32 +: 32];
      d = {x, x};
      p = {32'h0, d[58:27]} * 64'h9E37_79B1;
      h = p[31:0];
    end
    return h ^ {16'h0, h[31:16]};
  endfunction
  function automatic logic [63:0] ref2(input logic [63:0] key, input logic [31:0] s0, input logic [31:0] s1);
    return {ref_hash(key, 2, s1), ref_hash(key, 2, s0)};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run0(input logic [63:0] k);
    key0 = k;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    key0 = ~k;
    tick();
    tick();
    tick();
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_busy", {62'h0, busy0, busy1}, 64'h0);
    chk("rst_ready", {62'h0, ready0, ready1}, 64'h0);
    chk("rst_val0", val0, 64'h0);
    chk("rst_val1", {32'h0, val1}, 64'h0);
    #2 rst = 1'b1;
    tick();
    tick();
    chk("idle_flags", {60'h0, busy0, ready0, busy1, ready1}, 64'h0);
    chk("idle_val0", val0, 64'h0);
    key1 = 32'h1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("kv_busy", {62'h0, busy1, ready1}, 64'h2);
    tick();
    chk("kv_not_yet", {63'h0, ready1}, 64'h0);
    tick();
    chk("kv_ready", {62'h0, busy1, ready1}, 64'h1);
    chk("kv_val", {32'h0, val1}, 64'hC6EF_F0CF);
    key1 = 32'h0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("kv_hold", {32'h0, val1}, 64'hC6EF_F0CF);
    tick();
    tick();
    chk("kv_zero", {31'h0, ready1, val1}, 64'h1_0000_0000);
    key0 = 64'hdead_beef_abcd_ef00;
    start0 = 1'b1;
    prev = 64'h0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("b2b_accept", {62'h0, busy0, ready0}, 64'h2);
      chk("b2b_held", val0, prev);
      tick();
      chk("b2b_busy1", {62'h0, busy0, ready0}, 64'h2);
      tick();
      chk("b2b_busy2", {62'h0, busy0, ready0}, 64'h2);
      tick();
      chk("b2b_done", {62'h0, busy0, ready0}, 64'h1);
      chk("b2b_val", val0, ref2(64'hdead_beef_abcd_ef00, 32'h5bd1_e995, 32'h0));
      chk("b2b_ways_differ", {63'h0, val0[31:0] != val0[63:32]}, 64'h1);
      prev = val0;
    end
    start0 = 1'b0;
    tick();
    chk("done_hold", {62'h0, busy0, ready0}, 64'h1);
    key0 = 64'h0123_4567_89ab_cdef;
    start0 = 1'b1;
    tick();
    key0 = 64'hffff_0000_ffff_0000;
    tick();
    start0 = 1'b0;
    tick();
    chk("ign_busy", {62'h0, busy0, ready0}, 64'h2);
    tick();
    chk("ign_val", val0, ref2(64'h0123_4567_89ab_cdef, 32'h5bd1_e995, 32'h0));
    chk("ign_ready", {62'h0, busy0, ready0}, 64'h1);
    key0 = 64'h1111_2222_3333_4444;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_flags", {62'h0, busy0, ready0}, 64'h0);
    chk("arst_val", val0, 64'h0);
    #2 rst = 1'b1;
    tick();
    tick();
    chk("arst_idle", {62'h0, busy0, ready0}, 64'h0);
    run0(64'h1111_2222_3333_4444);
    chk("arst_rerun", val0, ref2(64'h1111_2222_3333_4444, 32'h5bd1_e995, 32'h0));
`ifdef HASH_MULTI_SEED_PROG_EN
    key0 = 64'h0000_0000_0000_0001;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    we0 = 1'b1;
    idx0 = 1'b1;
    sd0 = 32'h5bd1_e995;
    tick();
    we0 = 1'b0;
    tick();
    tick();
    chk("seed_old", val0, ref2(64'h1, 32'h5bd1_e995, 32'h0));
    run0(64'h0000_0000_0000_0001);
    chk("seed_new", {32'h0, val0[63:32]}, {32'h0, val0[31:0]});
    chk("seed_new_val", val0, ref2(64'h1, 32'h5bd1_e995, 32'h5bd1_e995));
    we1 = 1'b1;
    idx1 = 1'b1;
    sd1 = 32'hffff_ffff;
    tick();
    we1 = 1'b0;
    key1 = 32'h1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    chk("seed_oob", {32'h0, val1}, 64'hC6EF_F0CF);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
